// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the write-back stage: status codes, register
// IDs, instruction codes and the field values of a W-stage bubble.
package y86_pkg;

  // Processor status codes; 0 marks a bubble and is reported as AOK.
  localparam logic [3:0] STAT_BUB = 4'h0;
  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_HLT = 4'h2;
  localparam logic [3:0] STAT_ADR = 4'h3;
  localparam logic [3:0] STAT_INS = 4'h4;

  // Register ID meaning "no register".
  localparam logic [3:0] RNONE = 4'hF;

  // Instruction codes.
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Field values loaded into W for a bubble.
  localparam logic [3:0] BUB_STAT  = STAT_AOK;
  localparam logic [3:0] BUB_ICODE = I_NOP;
  localparam logic [3:0] BUB_DST   = RNONE;

  // True for a status that must stop the pipeline (anything but AOK/bubble).
  function automatic logic is_fault(input logic [3:0] stat);
    return (stat != STAT_AOK) && (stat != STAT_BUB);
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: NREGS x XLEN storage, two write ports (M port wins
// on a shared destination), two combinational read ports. ID 0xF reads 0.
// Optional write-through reads: define WB_REGFILE_BYPASS_EN.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [3:0]      dstE_i,
  input  logic [XLEN-1:0] valE_i,
  input  logic [3:0]      dstM_i,
  input  logic [XLEN-1:0] valM_i,
  input  logic [3:0]      srcA_i,
  input  logic [3:0]      srcB_i,
  output logic [XLEN-1:0] rvalA_o,
  output logic [XLEN-1:0] rvalB_o
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] storedA_s;
  logic [XLEN-1:0] storedB_s;

  // Next-state of every entry: M write overrides E write to the same ID.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = (we_i && (dstM_i == 4'(i))) ? valM_i :
                  (we_i && (dstE_i == 4'(i))) ? valE_i : regs_q[i];
    end
  end

  // Storage update with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Stored-value read ports; out-of-range IDs (RNONE) read zero.
  always_comb begin
    storedA_s = (srcA_i < 4'(NREGS)) ? regs_q[srcA_i] : '0;
    storedB_s = (srcB_i < 4'(NREGS)) ? regs_q[srcB_i] : '0;
  end

`ifdef WB_REGFILE_BYPASS_EN
  // Write-through: a committing write is visible in the same cycle.
  always_comb begin
    rvalA_o = (we_i && srcA_i != RNONE && srcA_i == dstM_i) ? valM_i :
              (we_i && srcA_i != RNONE && srcA_i == dstE_i) ? valE_i : storedA_s;
    rvalB_o = (we_i && srcB_i != RNONE && srcB_i == dstM_i) ? valM_i :
              (we_i && srcB_i != RNONE && srcB_i == dstE_i) ? valE_i : storedB_s;
  end
`else
  // Plain reads: same-cycle writes are covered by decode forwarding.
  always_comb begin
    rvalA_o = storedA_s;
    rvalB_o = storedB_s;
  end
`endif

endmodule

// File: rtl/y86_writeback_regfile.sv
// Y86-64 write-back stage: W pipeline register, sticky halt, status and the
// register file commit/read. Optional write-through reads: WB_REGFILE_BYPASS_EN.
module y86_writeback_regfile
  import y86_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            W_stall,
  input  logic            W_bubble,
  input  logic [3:0]      m_stat,
  input  logic [3:0]      M_icode,
  input  logic [3:0]      M_dstE,
  input  logic [XLEN-1:0] M_valE,
  input  logic [3:0]      M_dstM,
  input  logic [XLEN-1:0] m_valM,
  input  logic [3:0]      d_srcA,
  input  logic [3:0]      d_srcB,
  output logic [3:0]      W_stat,
  output logic [3:0]      W_icode,
  output logic [3:0]      W_dstE,
  output logic [XLEN-1:0] W_valE,
  output logic [3:0]      W_dstM,
  output logic [XLEN-1:0] W_valM,
  output logic [XLEN-1:0] d_rvalA,
  output logic [XLEN-1:0] d_rvalB,
  output logic [3:0]      Stat,
  output logic            halted
);

  logic [3:0]      stat_q, stat_d, icode_q, icode_d;
  logic [3:0]      dste_q, dste_d, dstm_q, dstm_d;
  logic [XLEN-1:0] vale_q, vale_d, valm_q, valm_d;
  logic            halted_q, halted_d;
  logic            freeze_s;
  logic            commit_s;

  // A faulting instruction in W (or a prior halt) freezes W so Stat keeps the fault code.
  assign freeze_s = halted_q || is_fault(stat_q);
  assign commit_s = (stat_q == STAT_AOK) && !halted_q && !rst;

  // W next-state: hold on stall/freeze, then bubble, else take M fields.
  always_comb begin
    stat_d  = stat_q;
    icode_d = icode_q;
    dste_d  = dste_q;
    vale_d  = vale_q;
    dstm_d  = dstm_q;
    valm_d  = valm_q;
    if (W_stall || freeze_s) begin
      stat_d  = stat_q;
      icode_d = icode_q;
    end else if (W_bubble) begin
      stat_d  = BUB_STAT;
      icode_d = BUB_ICODE;
      dste_d  = BUB_DST;
      vale_d  = '0;
      dstm_d  = BUB_DST;
      valm_d  = '0;
    end else begin
      stat_d  = m_stat;
      icode_d = M_icode;
      dste_d  = M_dstE;
      vale_d  = M_valE;
      dstm_d  = M_dstM;
      valm_d  = m_valM;
    end
  end

  // Sticky halt once a non-AOK instruction has been seen in W.
  assign halted_d = halted_q || is_fault(stat_q);

  // W register and halt flag, both cleared to the bubble/run state on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q   <= BUB_STAT;
      icode_q  <= BUB_ICODE;
      dste_q   <= BUB_DST;
      vale_q   <= '0;
      dstm_q   <= BUB_DST;
      valm_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      stat_q   <= stat_d;
      icode_q  <= icode_d;
      dste_q   <= dste_d;
      vale_q   <= vale_d;
      dstm_q   <= dstm_d;
      valm_q   <= valm_d;
      halted_q <= halted_d;
    end
  end

  assign W_stat  = stat_q;
  assign W_icode = icode_q;
  assign W_dstE  = dste_q;
  assign W_valE  = vale_q;
  assign W_dstM  = dstm_q;
  assign W_valM  = valm_q;
  assign halted  = halted_q;
  assign Stat    = (stat_q == STAT_BUB) ? STAT_AOK : stat_q;

  y86_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (commit_s),
    .dstE_i  (dste_q),
    .valE_i  (vale_q),
    .dstM_i  (dstm_q),
    .valM_i  (valm_q),
    .srcA_i  (d_srcA),
    .srcB_i  (d_srcB),
    .rvalA_o (d_rvalA),
    .rvalB_o (d_rvalB)
  );

endmodule

// File: tb/tb_y86_writeback_regfile.sv
// Directed scoreboard bench for y86_writeback_regfile.
module tb_y86_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst, W_stall, W_bubble;
  logic [3:0]  m_stat, M_icode, M_dstE, M_dstM, d_srcA, d_srcB;
  logic [63:0] M_valE, m_valM;
  logic [3:0]  W_stat, W_icode, W_dstE, W_dstM, Stat;
  logic [63:0] W_valE, W_valM, d_rvalA, d_rvalB;
  logic        halted;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  y86_writeback_regfile #(.XLEN(64), .NREGS(15)) dut (
    .clk(clk), .rst(rst), .W_stall(W_stall), .W_bubble(W_bubble),
    .m_stat(m_stat), .M_icode(M_icode), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .Stat(Stat), .halted(halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive_m(input logic [3:0] st, input logic [3:0] ic,
                         input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
    m_stat = st; M_icode = ic; M_dstE = de; M_valE = ve; M_dstM = dm; m_valM = vm;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [63:0] v);
    d_srcA = a;
    #1;
    expect_val(tag, v);
    chk(d_rvalA);
  endtask

  initial begin
    rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
    d_srcA = 4'h0; d_srcB = 4'h0;
    drive_m(4'h1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state: all reads zero, bubble in W.
    for (int i = 0; i < 16; i++) begin
      d_srcA = 4'(i);
      d_srcB = 4'(15 - i);
      #1;
      expect_val($sformatf("rst_rdA_%0d", i), 64'h0);
      chk(d_rvalA);
      expect_val($sformatf("rst_rdB_%0d", 15 - i), 64'h0);
      chk(d_rvalB);
    end
    expect_val("rst_stat", 64'h1);   chk({60'h0, Stat});
    expect_val("rst_halted", 64'h0); chk({63'h0, halted});
    expect_val("rst_dstE", 64'hF);   chk({60'h0, W_dstE});
    expect_val("rst_dstM", 64'hF);   chk({60'h0, W_dstM});
    expect_val("rst_icode", 64'h1);  chk({60'h0, W_icode});

    // Simple E write to r3; commit-cycle read depends on bypass.
    drive_m(4'h1, 4'h3, 4'h3, 64'h1234, 4'hF, 64'h0);
    tick();
    expect_val("w_dstE_r3", 64'h3);   chk({60'h0, W_dstE});
    expect_val("w_valE_r3", 64'h1234); chk(W_valE);
`ifdef WB_REGFILE_BYPASS_EN
    read_chk("commit_cycle_r3", 4'h3, 64'h1234);
`else
    read_chk("commit_cycle_r3", 4'h3, 64'h0);
`endif
    drive_m(4'h1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    tick();
    read_chk("after_commit_r3", 4'h3, 64'h1234);

    // Same destination on both ports: M value wins.
    drive_m(4'h1, 4'hB, 4'h4, 64'h10, 4'h4, 64'h20);
    tick();
    drive_m(4'h1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    tick();
    d_srcB = 4'h4;
    #1;
    expect_val("popq_r4", 64'h20); chk(d_rvalB);

    // Stall + bubble together: stall wins, W holds.
    drive_m(4'h1, 4'h3, 4'h7, 64'h77, 4'hF, 64'h0);
    tick();
    W_stall = 1'b1; W_bubble = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_m(4'h1, 4'h6, 4'(8 + k), 64'(k + 100), 4'h9, 64'(k));
      tick();
      expect_val($sformatf("stall_dstE_%0d", k), 64'h7);  chk({60'h0, W_dstE});
      expect_val($sformatf("stall_valE_%0d", k), 64'h77); chk(W_valE);
      expect_val($sformatf("stall_icode_%0d", k), 64'h3); chk({60'h0, W_icode});
      expect_val($sformatf("stall_dstM_%0d", k), 64'hF);  chk({60'h0, W_dstM});
    end
    W_stall = 1'b0;
    tick();
    expect_val("bub_icode", 64'h1); chk({60'h0, W_icode});
    expect_val("bub_dstE", 64'hF);  chk({60'h0, W_dstE});
    expect_val("bub_dstM", 64'hF);  chk({60'h0, W_dstM});
    expect_val("bub_valE", 64'h0);  chk(W_valE);
    expect_val("bub_stat", 64'h1);  chk({60'h0, W_stat});
    W_bubble = 1'b0;
    read_chk("stalled_r7", 4'h7, 64'h77);
    read_chk("no_r8", 4'h8, 64'h0);
    read_chk("no_r9", 4'h9, 64'h0);

    // Halt: faulting write suppressed, halted sticky, later writes ignored.
    drive_m(4'h2, 4'h0, 4'h5, 64'h99, 4'hF, 64'h0);
    tick();
    expect_val("hlt_stat_pre", 64'h2);   chk({60'h0, Stat});
    expect_val("hlt_halted_pre", 64'h0); chk({63'h0, halted});
    drive_m(4'h1, 4'h3, 4'h6, 64'h66, 4'hF, 64'h0);
    tick();
    expect_val("hlt_halted", 64'h1); chk({63'h0, halted});
    expect_val("hlt_stat", 64'h2);   chk({60'h0, Stat});
    tick();
    tick();
    expect_val("hlt_frozen_dstE", 64'h5); chk({60'h0, W_dstE});
    expect_val("hlt_stat_hold", 64'h2);   chk({60'h0, Stat});
    read_chk("hlt_r5", 4'h5, 64'h0);
    read_chk("hlt_r6", 4'h6, 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_val("rst_halted_clr", 64'h0); chk({63'h0, halted});
    expect_val("rst_stat_aok", 64'h1);   chk({60'h0, Stat});
    read_chk("rst_r3_clr", 4'h3, 64'h0);

    // RNONE destination writes nothing; baseline r1 survives.
    drive_m(4'h1, 4'h3, 4'h1, 64'h5, 4'hF, 64'h0);
    tick();
    drive_m(4'h1, 4'h3, 4'hF, 64'hFFFF, 4'hF, 64'h0);
    tick();
    drive_m(4'h1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    tick();
    for (int i = 0; i < 16; i++) begin
      read_chk($sformatf("rnone_r%0d", i), 4'(i), (i == 1) ? 64'h5 : 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
